// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector result collector: FSM encoding and chunk-width rule.
package vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WB      = 2'd2
  } state_t;

  localparam logic [2:0] VSEW_MAX = 3'd3;

  // Chunk width is the narrower of the element width and the lane datapath width.
  function automatic logic [6:0] sew_chunk_width(input logic [2:0] vsew, input int lane_width);
    logic [6:0] sew_bits;
    logic [6:0] lane_bits;
    sew_bits  = 7'd8 << vsew;
    lane_bits = 7'd1 << lane_width;
    return (sew_bits < lane_bits) ? sew_bits : lane_bits;
  endfunction

endpackage

// File: rtl/vec_chunk_insert.sv
// Merges one lane chunk into a vector/byte-mask pair; purely combinational, no backpressure.
module vec_chunk_insert #(
  parameter int VLEN = 128
) (
  input  logic              en,
  input  logic [VLEN-1:0]   data_in,
  input  logic [VLEN/8-1:0] mask_in,
  input  logic [63:0]       chunk,
  input  logic [9:0]        regi,
  input  logic [6:0]        cw,
  output logic [VLEN-1:0]   data_out,
  output logic [VLEN/8-1:0] mask_out
);

  logic [10:0] base;
  logic [10:0] end_bit;
  logic [10:0] byte_base;
  logic [10:0] byte_end;
  logic        fits;

  assign base      = {1'b0, regi};
  assign end_bit   = base + {4'b0, cw};
  assign byte_base = {4'b0, regi[9:3]};
  assign byte_end  = byte_base + {7'b0, cw[6:3]};
  // A chunk hanging past the top of the vector is dropped entirely, not truncated.
  assign fits      = (end_bit <= 11'(VLEN));

  always_comb begin
    data_out = data_in;
    mask_out = mask_in;
    if (en && fits) begin
      for (int i = 0; i < VLEN; i++) begin
        if (11'(i) >= base && 11'(i) < end_bit) begin
          data_out[i] = chunk[6'(11'(i) - base)];
        end
      end
      for (int j = 0; j < VLEN/8; j++) begin
        if (11'(j) >= byte_base && 11'(j) < byte_end) begin
          mask_out[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vec_result_collector.sv
// Collects lane results into a VLEN vector; alu_done in N -> wb_valid in N+1.
// Writeback holds data/mask/addr stable until wb_ready; start is ignored while busy.
module vec_result_collector
  import vec_pkg::*;
#(
  parameter  int VLEN       = 128,
  parameter  int LANE_WIDTH = 3,
  parameter  int NB_LANES   = 1,
  localparam int L          = 1 << NB_LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        vd_addr,
  input  logic [2:0]        vsew,
  input  logic [64*L-1:0]   lane_vd,
  input  logic [10*L-1:0]   lane_regi,
  input  logic [L-1:0]      lane_res,
  input  logic              alu_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_addr,
  output logic [VLEN-1:0]   wb_data,
  output logic [VLEN/8-1:0] wb_mask,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [2:0]        vsew_q;
  logic [6:0]        cw;
  logic [VLEN-1:0]   chain_data [0:L];
  logic [VLEN/8-1:0] chain_mask [0:L];

  assign cw            = sew_chunk_width(vsew_q, LANE_WIDTH);
  assign chain_data[0] = wb_data;
  assign chain_mask[0] = wb_mask;

  // Lane 0 is applied first so higher lanes overwrite it on overlap.
  for (genvar k = 0; k < L; k++) begin : g_lane
    vec_chunk_insert #(.VLEN(VLEN)) u_insert (
      .en       (lane_res[k]),
      .data_in  (chain_data[k]),
      .mask_in  (chain_mask[k]),
      .chunk    (lane_vd[64*k +: 64]),
      .regi     (lane_regi[10*k +: 10]),
      .cw       (cw),
      .data_out (chain_data[k+1]),
      .mask_out (chain_mask[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      vsew_q   <= 3'd0;
      wb_valid <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
      wb_mask  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (vsew > VSEW_MAX) begin
              err <= 1'b1;
            end else begin
              vsew_q  <= vsew;
              wb_addr <= vd_addr;
              wb_data <= '0;
              wb_mask <= '0;
              busy    <= 1'b1;
              state   <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          wb_data <= chain_data[L];
          wb_mask <= chain_mask[L];
          if (alu_done) begin
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_result_collector.sv
// Scoreboard bench for vec_result_collector at VLEN=128, 2 lanes, 8-bit chunks.
module tb_vec_result_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   vd_addr;
  logic [2:0]   vsew;
  logic [127:0] lane_vd;
  logic [19:0]  lane_regi;
  logic [1:0]   lane_res;
  logic         alu_done;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_mask;
  logic         busy;
  logic         err;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  logic [4:0]   mdl_addr;
  logic [127:0] mdl_data;
  logic [15:0]  mdl_mask;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  vec_result_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .vd_addr(vd_addr), .vsew(vsew),
    .lane_vd(lane_vd), .lane_regi(lane_regi), .lane_res(lane_res), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_mask(wb_mask), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_write(input int regi, input logic [7:0] d);
    if (regi + 8 <= 128) begin
      mdl_data[regi +: 8] = d;
      mdl_mask[regi / 8]  = 1'b1;
    end
  endfunction

  task automatic do_start(input logic [4:0] addr, input logic [2:0] sew);
    start = 1'b1; vd_addr = addr; vsew = sew;
    mdl_addr = addr; mdl_data = '0; mdl_mask = '0;
    tick();
    start = 1'b0; vd_addr = 5'd0; vsew = 3'd0;
  endtask

  // High bits of each lane word carry noise; only the low chunk may land in the vector.
  task automatic lane_step(input logic [1:0] res, input int r0, input logic [7:0] d0,
                           input int r1, input logic [7:0] d1, input bit done);
    lane_res  = res;
    lane_regi = {10'(r1), 10'(r0)};
    lane_vd   = {24'($urandom), 32'($urandom), d1, 24'($urandom), 32'($urandom), d0};
    alu_done  = done;
    if (res[0]) mdl_write(r0, d0);
    if (res[1]) mdl_write(r1, d1);
    if (done) exp_q.push_back('{mdl_addr, mdl_data, mdl_mask});
    tick();
    lane_res = 2'b00; alu_done = 1'b0;
  endtask

  task automatic wait_wb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_valid, busy, err} !== 3'b000 || wb_addr !== 5'd0 || wb_data !== '0 || wb_mask !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b err=%b addr=%h data=%h mask=%h, required all zero",
               wb_valid, busy, err, wb_addr, wb_data, wb_mask);
    end
  endtask

  task automatic test_fill();
    bit ok;
    wb_ready = 1'b1;
    do_start(5'd5, 3'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy: busy=%b required 1", busy); end
    for (int c = 0; c < 8; c++)
      lane_step(2'b11, 16*c, 8'(2*c), 16*c + 8, 8'(2*c + 1), c == 7);
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL fill_latency: wb_valid=%b required 1 one cycle after done", wb_valid); end
    wait_wb(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_timeout: wb_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.data || wb_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
        errors++; $display("FAIL fill_data: got %h required %h", wb_data, e.data);
      end
      checks++;
      if (wb_mask !== e.mask || wb_mask !== 16'hFFFF || wb_addr !== e.addr) begin
        errors++; $display("FAIL fill_mask_addr: mask=%h addr=%0d required mask=%h addr=%0d", wb_mask, wb_addr, e.mask, e.addr);
      end
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fill_idle: valid=%b busy=%b required 0 0", wb_valid, busy);
    end
  endtask

  task automatic test_sew2();
    bit ok;
    do_start(5'd9, 3'd2);
    lane_step(2'b01, 0, 8'h78, 0, 8'h00, 1'b0);
    lane_step(2'b01, 8, 8'h56, 0, 8'h00, 1'b0);
    lane_step(2'b01, 16, 8'h34, 0, 8'h00, 1'b0);
    lane_step(2'b01, 24, 8'h12, 0, 8'h00, 1'b1);
    wait_wb(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sew2_timeout: wb_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.data || wb_data[31:0] !== 32'h12345678 || wb_mask !== 16'h000F || wb_mask !== e.mask) begin
        errors++; $display("FAIL sew2_result: data=%h mask=%h required data=%h mask=%h", wb_data, wb_mask, e.data, e.mask);
      end
    end
    tick();
  endtask

  task automatic test_overlap();
    bit ok;
    do_start(5'd17, 3'd0);
    lane_step(2'b11, 40, 8'hAA, 40, 8'h55, 1'b0);
    lane_step(2'b11, 124, 8'h99, 128, 8'h77, 1'b1);
    wait_wb(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overlap_timeout: wb_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.data || wb_data[47:40] !== 8'h55) begin
        errors++; $display("FAIL overlap_data: got %h required %h", wb_data, e.data);
      end
      checks++;
      if (wb_mask !== e.mask || wb_mask !== 16'h0020) begin
        errors++; $display("FAIL overlap_mask: got %h required %h", wb_mask, e.mask);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    wb_ready = 1'b0;
    do_start(5'd21, 3'd0);
    lane_step(2'b11, 32, 8'hC3, 96, 8'h3C, 1'b1);
    wait_wb(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: wb_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front();
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== e.data || wb_mask !== e.mask || wb_addr !== e.addr) begin
          errors++; $display("FAIL bp_hold cycle %0d: valid=%b addr=%0d mask=%h data=%h required addr=%0d mask=%h data=%h",
                             c, wb_valid, wb_addr, wb_mask, wb_data, e.addr, e.mask, e.data);
        end
        start   = (c == 2);
        vd_addr = (c == 2) ? 5'd30 : 5'd0;
        tick();
        start = 1'b0;
      end
      // Start is held high on the handshake cycle too; it must not be taken.
      wb_ready = 1'b1; start = 1'b1; vd_addr = 5'd30;
      tick();
      start = 1'b0; vd_addr = 5'd0;
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_addr !== e.addr) begin
        errors++; $display("FAIL bp_release: valid=%b busy=%b addr=%0d required 0 0 %0d", wb_valid, busy, wb_addr, e.addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(5'd3, 3'd0);
    lane_step(2'b11, 64, 8'hEE, 72, 8'hDD, 1'b0);
    lane_step(2'b11, 80, 8'hCC, 88, 8'hBB, 1'b0);
    reset = 1'b1;
    lane_step(2'b01, 8, 8'h11, 0, 8'h00, 1'b0);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || wb_mask !== 16'h0 || wb_data !== '0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b mask=%h valid=%b data=%h required all zero", busy, wb_mask, wb_valid, wb_data);
    end
    do_start(5'd4, 3'd0);
    lane_step(2'b01, 0, 8'h3C, 0, 8'h00, 1'b1);
    wait_wb(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_rerun_timeout: wb_valid=0 required 1"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (wb_data !== e.data || wb_mask !== e.mask || wb_mask !== 16'h0001) begin
        errors++; $display("FAIL reset_rerun: data=%h mask=%h required data=%h mask=%h", wb_data, wb_mask, e.data, e.mask);
      end
    end
    tick();
  endtask

  task automatic test_err();
    start = 1'b1; vsew = 3'd4; vd_addr = 5'd12;
    tick();
    start = 1'b0; vsew = 3'd0; vd_addr = 5'd0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err=%b busy=%b required 1 0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_clear: err=%b busy=%b required 0 0", err, busy);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vd_addr = '0; vsew = '0; lane_vd = '0;
    lane_regi = '0; lane_res = '0; alu_done = 1'b0; wb_ready = 1'b1;
    mdl_addr = '0; mdl_data = '0; mdl_mask = '0;
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_fill();
    test_sew2();
    test_overlap();
    test_backpressure();
    test_reset_mid();
    test_err();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
